// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: line sync/filter, 11-bit frame deframer with odd
// parity, stop and timeout checks, and a first-word-fall-through scancode FIFO.
module ps2_kbd_rx #(
  parameter int FREQ_HZ    = 25_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_MS = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic [7:0]                    code_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          err_o,
  output logic                          overflow_o,
  input  logic                          clear_overflow_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int TO_CYCLES = FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int FW        = $clog2(FILTER_LEN + 1);
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          fclk_q, fclk_d, fdat_q, fdat_d, fclk_prev_q;
  logic [FW-1:0] fclk_cnt_q, fclk_cnt_d, fdat_cnt_q, fdat_cnt_d;
  logic          edge_s;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          push_q, push_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          pop_s, full_s, wr_en_s, ovf_set_s;

  // Clock-line glitch filter: flip only after FILTER_LEN consecutive differing samples
  always_comb begin
    fclk_d     = fclk_q;
    fclk_cnt_d = '0;
    if (clk_sync_q[1] != fclk_q) begin
      if (fclk_cnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_d = clk_sync_q[1];
      end else begin
        fclk_cnt_d = fclk_cnt_q + FW'(1);
      end
    end else begin
      fclk_cnt_d = '0;
    end
  end

  // Data-line glitch filter
  always_comb begin
    fdat_d     = fdat_q;
    fdat_cnt_d = '0;
    if (dat_sync_q[1] != fdat_q) begin
      if (fdat_cnt_q == FW'(FILTER_LEN - 1)) begin
        fdat_d = dat_sync_q[1];
      end else begin
        fdat_cnt_d = fdat_cnt_q + FW'(1);
      end
    end else begin
      fdat_cnt_d = '0;
    end
  end

  assign edge_s = fclk_prev_q & ~fclk_q;

  // Frame deframer; timeout takes priority and drops the partial frame
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    push_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q == S_IDLE || edge_s) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
    if (state_q != S_IDLE && !edge_s && tcnt_q == TW'(TO_CYCLES - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (edge_s) begin
      case (state_q)
        S_IDLE: begin
          if (!fdat_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          shift_d  = {fdat_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: begin
          par_d   = fdat_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (fdat_q && odd_parity_ok(shift_q, par_q)) begin
            push_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign pop_s     = (level_q != LW'(0)) && ready_i;
  assign full_s    = (level_q == LW'(FIFO_DEPTH));
  assign wr_en_s   = push_q && (!full_s || pop_s);
  assign ovf_set_s = push_q && full_s && !pop_s;

  // FIFO occupancy and sticky overflow (set beats clear)
  always_comb begin
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clear_overflow_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Front-end, deframer and FIFO state
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      fclk_q      <= 1'b1;
      fdat_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fclk_cnt_q  <= '0;
      fdat_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      push_q      <= 1'b0;
      err_q       <= 1'b0;
      tcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
      fclk_q      <= fclk_d;
      fdat_q      <= fdat_d;
      fclk_prev_q <= fclk_q;
      fclk_cnt_q  <= fclk_cnt_d;
      fdat_cnt_q  <= fdat_cnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      push_q      <= push_d;
      err_q       <= err_d;
      tcnt_q      <= tcnt_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign code_o     = mem_q[rd_ptr_q];
  assign valid_o    = (level_q != LW'(0));
  assign err_o      = err_q;
  assign overflow_o = ovf_q;
  assign level_o    = level_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: frames are generated from the PS/2 framing
// rules and expected codes/errors are queued when each frame is issued.
module tb_ps2_kbd_rx;
  localparam int DEPTH = 16;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       ready_i = 1'b0;
  logic       clear_overflow_i = 1'b0;
  logic [7:0] code_o;
  logic       valid_o, err_o, overflow_o;
  logic [4:0] level_o;

  ps2_kbd_rx #(.FREQ_HZ(1_000_000), .FILTER_LEN(8), .TIMEOUT_MS(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .code_o(code_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o),
    .overflow_o(overflow_o), .clear_overflow_i(clear_overflow_i), .level_o(level_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         exp_err  = 0;
  int         err_seen = 0;
  bit         rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count error pulses and compare every popped code with the queue head
  always @(negedge clk) begin
    if (!reset_i) begin
      if (err_o) err_seen++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got code 0x%0h expected no entry", code_o);
        end else begin
          check("pop_code", {24'd0, code_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Reference model of one frame: kind 0 good, 1 bad parity, 2 bad stop
  function automatic void issue(input logic [7:0] code, input int kind);
    if (kind != 0) exp_err++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(code);
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_i = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk_i = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input int kind);
    logic par, stop;
    par  = (~^code) ^ (kind == 1);
    stop = (kind != 2);
    issue(code, kind);
    send_bits({stop, par, code, 1'b0}, 11);
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1 ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {31'd0, n < 200}, 32'd1);
    @(posedge clk); #1 ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, {24'd0, code_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow_o}, 32'd0);
    check({tag, "_level"}, {27'd0, level_o}, 32'd0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_i = 1'b0;
    repeat (10) @(posedge clk);

    // Single good frame held in the FIFO
    send_frame(8'h1C, 0);
    @(negedge clk);
    check("f1c_level", {27'd0, level_o}, 32'd1);
    check("f1c_valid", {31'd0, valid_o}, 32'd1);
    check("f1c_code", {24'd0, code_o}, 32'h1C);
    check("f1c_err", err_seen, exp_err);
    drain();

    // Parity error then a good frame
    send_frame(8'h1C, 1);
    @(negedge clk);
    check("par_err", err_seen, exp_err);
    check("par_level", {27'd0, level_o}, 32'd0);
    send_frame(8'h5A, 0);
    @(negedge clk);
    check("f5a_level", {27'd0, level_o}, 32'd1);
    drain();

    // Three codes, popped on consecutive cycles
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    @(negedge clk);
    check("three_level", {27'd0, level_o}, 32'd3);
    @(posedge clk); #1 ready_i = 1'b1;
    repeat (4) @(negedge clk);
    check("three_valid_low", {31'd0, valid_o}, 32'd0);
    check("three_all_popped", exp_q.size(), 32'd0);
    @(posedge clk); #1 ready_i = 1'b0;

    // Overflow: 17 frames into a 16-entry FIFO
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0);
    @(negedge clk);
    check("ovf_level", {27'd0, level_o}, 32'd16);
    check("ovf_set", {31'd0, overflow_o}, 32'd1);
    drain();
    check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
    @(posedge clk); #1 clear_overflow_i = 1'b1;
    @(posedge clk); #1 clear_overflow_i = 1'b0;
    @(negedge clk);
    check("ovf_cleared", {31'd0, overflow_o}, 32'd0);

    // Aborted frame ends in timeout
    exp_err++;
    send_bits({2'b11, 8'h00, 1'b0}, 5);
    repeat (2300) @(posedge clk);
    @(negedge clk);
    check("timeout_err", err_seen, exp_err);
    check("timeout_level", {27'd0, level_o}, 32'd0);
    send_frame(8'h29, 0);
    @(negedge clk);
    check("f29_level", {27'd0, level_o}, 32'd1);
    drain();

    // Short clock glitch while idle
    @(posedge clk); #1 ps2_clk_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk_i = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("glitch_err", err_seen, exp_err);
    check("glitch_level", {27'd0, level_o}, 32'd0);

    // Random frames with random consumer stalls
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int r;
          r = $urandom_range(0, 5);
          send_frame(8'($urandom), (r == 4) ? 1 : (r == 5) ? 2 : 0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1 ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    @(negedge clk);
    check("rand_err", err_seen, exp_err);
    check("rand_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a frame
    send_bits({2'b11, 8'hFF, 1'b0}, 4);
    @(posedge clk); #1 reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1 reset_i = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(8'h1C, 0);
    @(negedge clk);
    check("post_reset_level", {27'd0, level_o}, 32'd1);
    check("post_reset_err", err_seen, exp_err);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
